// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//
// Integer register file for the single-cycle RISC-V datapath. Two combinational
// read ports feed the ALU operands; one synchronous write port takes the
// write-back result. x0 is hard-wired to zero.
//
// Extras:
//   * Optional write-to-read bypass (BYPASS=1): a write presented this cycle is
//     forwarded to any read port addressing the same non-zero register.
//   * Background bulk-clear engine: a one-cycle clr_req zeroes x1..x(NREGS-1),
//     one register per clock, while busy is high. Writes are silently dropped
//     and bypass is disabled during the clear.
//
// Parameters:
//   XLEN    data width of each register
//   NREGS   number of architectural registers (must equal 2**ADDR_W)
//   ADDR_W  register address width
//   BYPASS  1 = forward same-cycle write data to read ports, 0 = storage only
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      asynchronous, active-high reset
//   raddr1   read port 1 address (operand_a)
//   raddr2   read port 2 address (operand_b)
//   rdata1   read port 1 data
//   rdata2   read port 2 data
//   wr_en    write enable
//   waddr    write address
//   wdata    write data
//   clr_req  single-cycle request to zero all registers
//   busy     clear engine active; writes are dropped while high
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              clr_req,
    output logic              busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Index of the last register; the clear engine exits after zeroing it.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [XLEN-1:0]   regs [NREGS];

    // A write is committed only in IDLE and never to x0.
    logic write_ok;
    assign write_ok = (state == IDLE) && wr_en && (waddr != '0);

    // -------------------------------------------------------------------------
    // State, clear engine and storage
    // -------------------------------------------------------------------------
    // NOTE: the register array is reset explicitly because the architecture
    // requires every register to read 0 straight out of reset; this makes the
    // storage flops rather than an inferable RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, so the order of statements here is irrelevant.
            case (state)
                IDLE: begin
                    // A write in the same cycle as clr_req still lands; it is
                    // then zeroed when the engine reaches that index.
                    if (write_ok) begin
                        regs[waddr] <= wdata;
                    end
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= ADDR_W'(1);  // x0 is already zero
                        busy  <= 1'b1;
                    end
                end

                CLEAR: begin
                    // wr_en and clr_req are ignored in this state.
                    regs[cnt] <= '0;
                    if (cnt == LAST_IDX) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Combinational read ports
    // -------------------------------------------------------------------------
    // Forward only what would actually be written this edge; write_ok already
    // excludes x0 and the CLEAR state.
    function automatic logic [XLEN-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [XLEN-1:0] value;
        if (addr == '0) begin
            value = '0;
        end else if (BYPASS && write_ok && (waddr == addr)) begin
            value = wdata;
        end else begin
            value = regs[addr];
        end
        return value;
    endfunction

    // NOTE: each output gets a value on every path through this block, so no
    // latch is inferred.
    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
//
// Directed test for reg_file. Two instances share all inputs: u_byp with
// BYPASS=1 and u_nob with BYPASS=0, so bypass and non-bypass read behaviour
// can be compared on identical stimulus.
// -----------------------------------------------------------------------------
module tb_reg_file;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              run_clk;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic              wr_en;
    logic [ADDR_W-1:0] waddr;
    logic [XLEN-1:0]   wdata;
    logic              clr_req;

    logic [XLEN-1:0]   b_rdata1, b_rdata2, n_rdata1, n_rdata2;
    logic              b_busy, n_busy;

    int checks   = 0;
    int failures = 0;

    reg_file #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_byp (
        .clk     (clk),
        .rst     (rst),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .rdata1  (b_rdata1),
        .rdata2  (b_rdata2),
        .wr_en   (wr_en),
        .waddr   (waddr),
        .wdata   (wdata),
        .clr_req (clr_req),
        .busy    (b_busy)
    );

    reg_file #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_nob (
        .clk     (clk),
        .rst     (rst),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .rdata1  (n_rdata1),
        .rdata2  (n_rdata2),
        .wr_en   (wr_en),
        .waddr   (waddr),
        .wdata   (wdata),
        .clr_req (clr_req),
        .busy    (n_busy)
    );

    // Clock held low until run_clk is set, so reset can be checked edge-free.
    initial clk = 1'b0;
    always begin
        #5;
        if (run_clk) clk = ~clk;
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cycles;

    initial begin
        run_clk = 1'b0;
        rst     = 1'b0;
        raddr1  = '0;
        raddr2  = '0;
        wr_en   = 1'b0;
        waddr   = '0;
        wdata   = '0;
        clr_req = 1'b0;

        // ---- Asynchronous reset with no clock edge ----
        #2;
        rst    = 1'b1;
        raddr1 = 5'd5;
        raddr2 = 5'd31;
        #1;
        check("rst_b_rdata1", b_rdata1, 32'h0);
        check("rst_b_rdata2", b_rdata2, 32'h0);
        check("rst_b_busy",   {31'b0, b_busy}, 32'h0);
        check("rst_n_rdata1", n_rdata1, 32'h0);
        check("rst_n_rdata2", n_rdata2, 32'h0);
        check("rst_n_busy",   {31'b0, n_busy}, 32'h0);
        #2;
        rst     = 1'b0;
        #2;
        run_clk = 1'b1;
        tick();

        // ---- Write x3, read back next cycle ----
        wr_en = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
        tick();
        wr_en  = 1'b0;
        raddr1 = 5'd3;
        #1;
        check("wr_x3_b", b_rdata1, 32'hDEADBEEF);
        check("wr_x3_n", n_rdata1, 32'hDEADBEEF);

        // ---- Write to x0 is discarded and never bypassed ----
        wr_en = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr2 = 5'd0;
        #1;
        check("x0_nobypass_b", b_rdata2, 32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        check("x0_read_b", b_rdata2, 32'h0);
        check("x0_read_n", n_rdata2, 32'h0);

        // ---- Same-cycle bypass on both ports ----
        wr_en = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        check("byp_b_rdata1", b_rdata1, 32'hA5A5A5A5);
        check("byp_b_rdata2", b_rdata2, 32'hA5A5A5A5);
        check("byp_n_rdata1", n_rdata1, 32'h0);
        check("byp_n_rdata2", n_rdata2, 32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        check("nob_after_edge", n_rdata1, 32'hA5A5A5A5);

        // ---- Preload x1..x31 with index*0x11 ----
        for (int i = 1; i < NREGS; i++) begin
            wr_en = 1'b1; waddr = ADDR_W'(i); wdata = 32'(i * 32'h11);
            tick();
        end
        wr_en  = 1'b0;
        raddr1 = 5'd31;
        raddr2 = 5'd9;
        #1;
        check("preload_x31", b_rdata1, 32'h0000020F);
        check("preload_x9",  b_rdata2, 32'h00000099);

        // ---- Bulk clear: busy length, dropped write, no bypass ----
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_busy_rise", {31'b0, b_busy}, 32'h1);
        wr_en = 1'b1; waddr = 5'd9; wdata = 32'hFFFFFFFF; raddr1 = 5'd9;
        #1;
        check("clr_no_bypass", b_rdata1, 32'h00000099);
        busy_cycles = 0;
        while (b_busy && busy_cycles < 100) begin
            busy_cycles++;
            tick();
        end
        wr_en = 1'b0;
        check("clr_busy_cycles", 32'(busy_cycles), 32'd31);
        check("clr_n_busy_low",  {31'b0, n_busy}, 32'h0);
        for (int i = 0; i < NREGS; i++) begin
            raddr1 = ADDR_W'(i);
            raddr2 = ADDR_W'(i);
            #1;
            check($sformatf("clr_zero_b_x%0d", i), b_rdata1, 32'h0);
            check($sformatf("clr_zero_n_x%0d", i), n_rdata2, 32'h0);
        end

        // ---- clr_req together with a write to x4 ----
        tick();
        wr_en = 1'b1; waddr = 5'd4; wdata = 32'h55; clr_req = 1'b1;
        tick();
        wr_en = 1'b0; clr_req = 1'b0; raddr1 = 5'd4;
        #1;
        check("clrwr_x4_written", b_rdata1, 32'h55);
        busy_cycles = 0;
        while (b_busy && busy_cycles < 100) begin
            busy_cycles++;
            tick();
        end
        check("clrwr_busy_cycles", 32'(busy_cycles), 32'd31);
        check("clrwr_x4_cleared", b_rdata1, 32'h0);

        // ---- Reset in clear cycle 10 ----
        wr_en = 1'b1; waddr = 5'd6;  wdata = 32'hAB;
        tick();
        waddr = 5'd30; wdata = 32'h1E;
        tick();
        wr_en = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        raddr1 = 5'd30; raddr2 = 5'd6;
        #1;
        check("mid_busy_high",  {31'b0, b_busy}, 32'h1);
        check("mid_x30_intact", b_rdata1, 32'h1E);
        check("mid_x6_cleared", b_rdata2, 32'h0);
        rst = 1'b1;
        #1;
        check("mid_rst_b_busy", {31'b0, b_busy}, 32'h0);
        check("mid_rst_n_busy", {31'b0, n_busy}, 32'h0);
        check("mid_rst_b_x30",  b_rdata1, 32'h0);
        check("mid_rst_n_x30",  n_rdata1, 32'h0);
        rst = 1'b0;

        // ---- Write accepted right after reset ----
        wr_en = 1'b1; waddr = 5'd2; wdata = 32'h77; raddr1 = 5'd2;
        tick();
        wr_en = 1'b0;
        #1;
        check("post_rst_x2_b", b_rdata1, 32'h77);
        check("post_rst_x2_n", n_rdata1, 32'h77);
        check("post_rst_busy", {31'b0, b_busy}, 32'h0);
        raddr2 = 5'd30;
        #1;
        check("post_rst_x30", b_rdata2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
